// File: rtl/ps2_pkg.sv
// ps2_pkg: types and constants shared by the PS/2 receive and transmit blocks.
//   rx_state_t       - receiver FSM state encoding (2 bits)
//   FRAME_BITS       - bits per device-to-host frame (start, 8 data, parity, stop)
//   ACK/BAT_OK/...   - common device response and host command bytes
//   odd_parity_ok()  - true when data ones plus the parity bit is odd
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } rx_state_t;

    localparam int FRAME_BITS = 11;

    localparam logic [7:0] ACK              = 8'hFA;
    localparam logic [7:0] BAT_OK           = 8'hAA;
    localparam logic [7:0] RESEND           = 8'hFE;
    localparam logic [7:0] ENABLE_REPORTING = 8'hF4;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_rx_if.sv
// ps2_rx_if: pin-side inputs and byte-side outputs of the PS/2 receiver.
//   master - the receiver: takes the raw pins and enable, drives byte/status
//   slave  - the consumer (packet decoder / bench): sees byte/status
interface ps2_rx_if;
    logic       rx_en_i;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       idle_o;
    logic [1:0] state_o;
    logic [3:0] bit_count_o;

    modport master (
        input  rx_en_i, ps2_clk_i, ps2_data_i,
        output rx_data_o, rx_valid_o, parity_err_o, frame_err_o,
               idle_o, state_o, bit_count_o
    );

    modport slave (
        output rx_en_i, ps2_clk_i, ps2_data_i,
        input  rx_data_o, rx_valid_o, parity_err_o, frame_err_o,
               idle_o, state_o, bit_count_o
    );
endinterface

// File: rtl/ps2_filter.sv
// ps2_filter: conditions the asynchronous PS/2 pins.
//   clk_i, reset_ni - system clock, async active-low reset
//   ps2_clk_i       - raw PS/2 clock pin; two-flop synced then debounced
//   ps2_data_i      - raw PS/2 data pin; two-flop synced only
//   clk_fall_o      - one-cycle pulse when the debounced clock goes 1->0
//   data_o          - synchronized data, valid to sample alongside clk_fall_o
module ps2_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_fall_o,
    output logic data_o
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]       clk_sync;
    logic [1:0]       data_sync;
    logic             clk_filt;
    logic [CNT_W-1:0] cnt;

    // Lines idle high, so synchronizers and filter come out of reset at 1
    // and no spurious edge appears on release.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            clk_filt   <= 1'b1;
            cnt        <= '0;
            clk_fall_o <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk_i};
            data_sync  <= {data_sync[0], ps2_data_i};
            clk_fall_o <= 1'b0;
            // cnt counts consecutive samples disagreeing with the filtered
            // level; any agreeing sample restarts the run.
            if (clk_sync[1] == clk_filt) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
                clk_filt   <= clk_sync[1];
                cnt        <= '0;
                clk_fall_o <= clk_filt;   // old level 1 means this is 1->0
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign data_o = data_sync[1];

endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: receives 11-bit device-to-host PS/2 frames and reports one byte
// (or one error) per frame.
//   clk_i, reset_ni - system clock, async active-low reset
//   bus (master)    - rx_en_i, raw ps2 pins in; rx_data_o, rx_valid_o,
//                     parity_err_o, frame_err_o, idle_o, state_o,
//                     bit_count_o out
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200_000
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    ps2_rx_if.master     bus
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int SR_W = FRAME_BITS - 1;

    logic              clk_fall;
    logic              data_s;
    rx_state_t         state;
    logic [3:0]        bit_cnt;
    logic [SR_W-1:0]   shift_reg;
    logic [TO_W-1:0]   to_cnt;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              parity_err;
    logic              frame_err;

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .ps2_clk_i  (bus.ps2_clk_i),
        .ps2_data_i (bus.ps2_data_i),
        .clk_fall_o (clk_fall),
        .data_o     (data_s)
    );

    // Bits shift in at the MSB. When the stop bit arrives the register holds
    // start at [0], data LSB..MSB at [8:1] and parity at [9]; the stop bit
    // itself is taken straight from data_s so the verdict is registered in
    // the stop-edge cycle and its pulse coincides with the CHECK state.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            to_cnt     <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (clk_fall && bus.rx_en_i && !data_s) begin
                        state     <= SHIFT;
                        bit_cnt   <= 4'd1;
                        shift_reg <= {data_s, shift_reg[SR_W-1:1]};
                    end
                end
                SHIFT: begin
                    if (!bus.rx_en_i) begin
                        // host inhibit or transmit start: drop the frame silently
                        state   <= IDLE;
                        bit_cnt <= '0;
                        to_cnt  <= '0;
                    end else if (clk_fall) begin
                        shift_reg <= {data_s, shift_reg[SR_W-1:1]};
                        bit_cnt   <= bit_cnt + 4'd1;
                        to_cnt    <= '0;
                        if (bit_cnt == 4'(FRAME_BITS - 1)) begin
                            state <= CHECK;
                            if (!data_s)
                                frame_err <= 1'b1;
                            else if (!odd_parity_ok(shift_reg[8:1], shift_reg[9]))
                                parity_err <= 1'b1;
                            else begin
                                rx_data  <= shift_reg[8:1];
                                rx_valid <= 1'b1;
                            end
                        end
                    end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                        bit_cnt   <= '0;
                        to_cnt    <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    // edges here cannot occur with legal PS/2 timing; ignored
                    state   <= IDLE;
                    bit_cnt <= '0;
                end
                default: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.rx_data_o    = rx_data;
    assign bus.rx_valid_o   = rx_valid;
    assign bus.parity_err_o = parity_err;
    assign bus.frame_err_o  = frame_err;
    assign bus.idle_o       = (state == IDLE);
    assign bus.state_o      = state;
    assign bus.bit_count_o  = bit_cnt;

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
Receives device-to-host PS/2 frames from the keyboard/mouse lines and delivers one validated byte per frame. It sits beside ps2_tx on the shared PS/2 clock/data pins. Its output feeds the mouse/keyboard packet decoder that drives cursor and sand-brush input. It shares the line with ps2_tx: reception is gated off while the host transmits.

Parameters:
FILTER_LEN, 8, consecutive identical synchronized samples required before the filtered PS/2 clock changes level.
TIMEOUT_CYCLES, 200_000, system cycles allowed between PS/2 clock falling edges mid-frame (2 ms at 100 MHz).

Ports:
clk_i  input  1  system clock.
reset_ni  input  1  asynchronous, active-low reset.
rx_en_i  input  1  reception enable; tie to ps2_tx idle_o.
ps2_clk_i  input  1  raw PS/2 clock pin (asynchronous).
ps2_data_i  input  1  raw PS/2 data pin (asynchronous).
rx_data_o  output  8  last received byte.
rx_valid_o  output  1  one-cycle pulse, rx_data_o valid.
parity_err_o  output  1  one-cycle pulse, odd-parity check failed.
frame_err_o  output  1  one-cycle pulse, bad start/stop bit or timeout.
idle_o  output  1  high in IDLE.
state_o  output  2  current state, for debug.
bit_count_o  output  4  bits captured in current frame, for debug.

Behaviour:
- Reset (reset_ni low, async) sets the following values:
  - rx_data_o = 0x00; rx_valid_o, parity_err_o and frame_err_o = 0.
  - idle_o = 1; state = IDLE; bit_count = 0; shift register = 0.
  - Synchronizer and filter outputs = 1 (line idle-high); timeout counter = 0.
- Input conditioning:
  - Two-flop synchronizer on each pin.
  - The filtered clock changes only after FILTER_LEN consecutive equal synchronized samples.
  - Data is used synchronized only.
- A falling edge is a filtered-clock transition 1->0. It is a single-cycle event; data is sampled in that same cycle.
- Frame format: 11 bits.
  - Start bit = 0.
  - 8 data bits, LSB first.
  - Odd parity bit: data ones plus parity bit is odd.
  - Stop bit = 1.
- States:
  - IDLE:
    - Falling edge with rx_en_i=1 and data=0 -> SHIFT, bit_count=1.
    - Falling edge with data=1 is ignored.
    - rx_en_i=0 ignores all edges.
  - SHIFT:
    - Each falling edge captures one bit and increments bit_count.
    - After capturing the stop bit (bit_count reaches 11) -> CHECK.
  - CHECK (single cycle):
    - Evaluate the frame, drive outputs, return to IDLE, clear bit_count.
- CHECK priority:
  - Stop bit = 0: frame_err_o pulses; rx_data_o unchanged.
  - Else parity wrong: parity_err_o pulses; rx_data_o unchanged.
  - Else: rx_data_o updated and rx_valid_o pulses in the same cycle.
  - At most one of the three pulses is active per frame.
- Latency: the pulse appears exactly 1 cycle after the stop-bit falling-edge cycle.
- Timeout:
  - In SHIFT, the counter increments every cycle and clears on each falling edge.
  - When it reaches TIMEOUT_CYCLES-1: frame_err_o pulses, state -> IDLE, bit_count=0.
- rx_en_i deasserted in SHIFT aborts immediately: -> IDLE, no pulse. This covers host inhibit and the start of ps2_tx.
- Glitches shorter than FILTER_LEN cycles on ps2_clk_i produce no edge.
- Reset asserted mid-frame returns everything to reset values at once. No partial byte is ever reported.
- A falling edge in the CHECK cycle is ignored; PS/2 timing makes this impossible in normal operation.

Decomposition:
- Package ps2_pkg contains:
  - rx_state_t enum {IDLE, SHIFT, CHECK}, 2 bits.
  - FRAME_BITS = 11.
  - Command/response constants shared with ps2_tx: ACK = 0xFA, BAT_OK = 0xAA, RESEND = 0xFE, ENABLE_REPORTING = 0xF4.
- Sub-module ps2_filter: two-flop synchronizer plus FILTER_LEN debounce plus falling-edge pulse. One instance for clock and a sync-only path for data. ps2_tx reuses it.

Test Plan:
1. Send frame 0xFA with parity 1, stop 1, at a 16 kHz PS/2 clock -> rx_valid_o pulses once 1 cycle after the 11th falling edge; rx_data_o=0xFA; no error pulses.
2. Send 0x01 with parity 1 (wrong) -> parity_err_o pulses once; rx_valid_o stays 0; rx_data_o keeps its prior value 0xFA.
3. Send 0xAA with parity 1 and stop bit 0 -> frame_err_o pulses; no rx_valid_o.
4. TIMEOUT_CYCLES=1000: stop the PS/2 clock after 5 bits -> frame_err_o pulses 1000 cycles after the last edge; idle_o=1; a following 0x00 frame (parity 1) is received correctly.
5. Inject 3-cycle low glitches on ps2_clk_i while a 0xF4 frame (parity 0) is received -> exactly 0xF4 is reported once; bit_count_o never skips.
6. Assert reset_ni=0 after 6 bits, then release it and send 0xFE; separately drop rx_en_i mid-frame -> no pulse from either aborted frame; 0xFE is received; idle_o=1 after each abort.
